// File: rtl/mac_pkg.sv
// Shared definitions for the carry-save MAC accumulator: default widths,
// FSM state encoding and a small width helper.
package mac_pkg;

   localparam int IN_W_DEF  = 32;
   localparam int ACC_W_DEF = 40;
   localparam int CHUNK_DEF = 8;

   typedef enum logic [1:0] {
      ST_ACCUM   = 2'd0,
      ST_RESOLVE = 2'd1,
      ST_OUTPUT  = 2'd2
   } mac_state_e;

   // Counter width for n values, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/csa_row_4to2.sv
// Vector 4:2 compressor built from two cascaded 3:2 rows.
// The carry rows leave already shifted into their weight position; the bits
// that fall off the top are exported so the caller can flag overflow.
module csa_row_4to2 #(
   parameter int W = 40
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   input  logic [W-1:0] d,
   output logic [W-1:0] s,
   output logic [W-1:0] cy,
   output logic         msb1,
   output logic         msb2
);

   logic [W-1:0] s1;
   logic [W-1:0] c1;
   logic [W-1:0] c1_sh;
   logic [W-1:0] c2;

   // Per-bit full-adder cells for both rows.
   for (genvar i = 0; i < W; i++) begin : g_bit
      assign s1[i] = a[i] ^ b[i] ^ c[i];
      assign c1[i] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
      assign s[i]  = s1[i] ^ c1_sh[i] ^ d[i];
      assign c2[i] = (s1[i] & c1_sh[i]) | (s1[i] & d[i]) | (c1_sh[i] & d[i]);
   end

   // First-row carries move up one weight before entering the second row.
   assign c1_sh = {c1[W-2:0], 1'b0};
   assign cy    = {c2[W-2:0], 1'b0};

   // Carries pushed out of bit W-1 by either shift are lost weight 2^W.
   assign msb1  = c1[W-1];
   assign msb2  = c2[W-1];

endmodule

// File: rtl/mac_cs_accumulator.sv
// Carry-save accumulator for a MAC datapath. Beats from the compressor tree
// are folded into a redundant (sum, carry) pair with a 4:2 row; at the end of
// a frame the pair is resolved CHUNK bits per cycle by one narrow adder, and
// the binary result is presented on a valid/ready output port.
module mac_cs_accumulator
   import mac_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int ACC_W = ACC_W_DEF,
   parameter int CHUNK = CHUNK_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_sum,
   input  logic [IN_W-1:0]  in_carry,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic             out_ovf
);

   localparam int NCHUNK = ACC_W / CHUNK;
   localparam int IDX_W  = idx_width(NCHUNK);
   localparam int SW     = CHUNK + 1;

   mac_state_e       state;
   mac_state_e       state_nxt;

   logic [ACC_W-1:0] acc_s;
   logic [ACC_W-1:0] acc_c;
   logic             ovf;
   logic [IDX_W-1:0] cidx;
   logic             cpa_cy;

   logic [ACC_W-1:0] sum_x;
   logic [ACC_W-1:0] car_x;
   logic [ACC_W-1:0] csa_s;
   logic [ACC_W-1:0] csa_c;
   logic             csa_msb1;
   logic             csa_msb2;

   logic             accept;
   logic             last_slice;
   logic             handshake;
   logic [SW-1:0]    slice_sum;

   assign sum_x = ACC_W'(in_sum);
   assign car_x = ACC_W'(in_carry);

   csa_row_4to2 #(
      .W(ACC_W)
   ) u_csa (
      .a    (acc_s),
      .b    (acc_c),
      .c    (sum_x),
      .d    (car_x),
      .s    (csa_s),
      .cy   (csa_c),
      .msb1 (csa_msb1),
      .msb2 (csa_msb2)
   );

   assign accept     = in_valid && in_ready;
   assign last_slice = (cidx == IDX_W'(NCHUNK - 1));
   assign handshake  = out_valid && out_ready;

   // The one carry-propagate adder: the current CHUNK slice plus the carry
   // rippled in from the previous cycle.
   assign slice_sum = {1'b0, acc_s[cidx*CHUNK +: CHUNK]}
                    + {1'b0, acc_c[cidx*CHUNK +: CHUNK]}
                    + SW'(cpa_cy);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_ACCUM;
      else     state <= state_nxt;
   end

   // Next-state logic; clear returns to ACCUM from anywhere.
   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = ST_ACCUM;
      end else begin
         case (state)
            ST_ACCUM:   if (accept && in_last) state_nxt = ST_RESOLVE;
            ST_RESOLVE: if (last_slice)        state_nxt = ST_OUTPUT;
            ST_OUTPUT:  if (handshake)         state_nxt = ST_ACCUM;
            default:                           state_nxt = ST_ACCUM;
         endcase
      end
   end

   // Input handshake: only ACCUM takes beats, and never while reset or
   // clear is asserted.
   always_comb begin
      in_ready = (state == ST_ACCUM) && !clear && !rst;
   end

   // Accumulator, resolve slices and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_s     <= '0;
         acc_c     <= '0;
         ovf       <= 1'b0;
         cidx      <= '0;
         cpa_cy    <= 1'b0;
         out_valid <= 1'b0;
         out_acc   <= '0;
         out_ovf   <= 1'b0;
      end else if (clear) begin
         acc_s     <= '0;
         acc_c     <= '0;
         ovf       <= 1'b0;
         cidx      <= '0;
         cpa_cy    <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ST_ACCUM: begin
               if (accept) begin
                  acc_s <= csa_s;
                  acc_c <= csa_c;
                  ovf   <= ovf | csa_msb1 | csa_msb2;
                  if (in_last) begin
                     cidx   <= '0;
                     cpa_cy <= 1'b0;
                  end
               end
            end
            ST_RESOLVE: begin
               out_acc[cidx*CHUNK +: CHUNK] <= slice_sum[CHUNK-1:0];
               cpa_cy <= slice_sum[CHUNK];
               cidx   <= cidx + 1'b1;
               if (last_slice) begin
                  // Carry out of the top slice is weight 2^ACC_W.
                  cidx      <= '0;
                  ovf       <= ovf | slice_sum[CHUNK];
                  out_ovf   <= ovf | slice_sum[CHUNK];
                  out_valid <= 1'b1;
               end
            end
            ST_OUTPUT: begin
               if (handshake) begin
                  acc_s     <= '0;
                  acc_c     <= '0;
                  ovf       <= 1'b0;
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_cs_accumulator.sv
// Bench for mac_cs_accumulator: one default (ACC_W=40) instance and one
// ACC_W=32 instance so overflow is reachable. Results are compared against
// the plain integer sum of every beat in the frame.
module tb_mac_cs_accumulator;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        clr [2];
   logic        iv  [2];
   logic        il  [2];
   logic        ordy[2];
   logic [31:0] isum[2];
   logic [31:0] icar[2];

   logic        ir0, ir1, ov0, ov1, oovf0, oovf1;
   logic [39:0] oacc0;
   logic [31:0] oacc1;

   logic        ir  [2];
   logic        ov  [2];
   logic        oovf[2];
   logic [39:0] oacc[2];

   always_comb begin
      ir[0]   = ir0;
      ir[1]   = ir1;
      ov[0]   = ov0;
      ov[1]   = ov1;
      oovf[0] = oovf0;
      oovf[1] = oovf1;
      oacc[0] = oacc0;
      oacc[1] = {8'h00, oacc1};
   end

   int n_tests = 0;
   int n_fail  = 0;

   mac_cs_accumulator u_dut40 (
      .clk(clk), .rst(rst), .clear(clr[0]),
      .in_valid(iv[0]), .in_ready(ir0),
      .in_sum(isum[0]), .in_carry(icar[0]), .in_last(il[0]),
      .out_valid(ov0), .out_ready(ordy[0]),
      .out_acc(oacc0), .out_ovf(oovf0)
   );

   mac_cs_accumulator #(.IN_W(32), .ACC_W(32), .CHUNK(8)) u_dut32 (
      .clk(clk), .rst(rst), .clear(clr[1]),
      .in_valid(iv[1]), .in_ready(ir1),
      .in_sum(isum[1]), .in_carry(icar[1]), .in_last(il[1]),
      .out_valid(ov1), .out_ready(ordy[1]),
      .out_acc(oacc1), .out_ovf(oovf1)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one beat and hold it until the DUT takes it.
   task automatic send_beat(input int d, input logic [31:0] s, input logic [31:0] c,
                            input logic last);
      int t = 0;
      iv[d] = 1'b1; isum[d] = s; icar[d] = c; il[d] = last;
      while (!ir[d] && t < 200) begin step(); t++; end
      if (!ir[d]) begin
         chk("in_ready timeout", 64'(ir[d]), 64'd1);
         iv[d] = 1'b0;
         return;
      end
      step();
      iv[d] = 1'b0; il[d] = 1'b0;
   endtask

   // Called just after the last beat's accepting edge. Waits for out_valid,
   // stalls the consumer, checks the result holds, then takes it.
   task automatic get_result(input int d, input int stall, output logic [39:0] acc,
                             output logic f, output int lat);
      int t = 0;
      logic [39:0] a0;
      logic f0;
      logic stable = 1'b1;
      lat = 1;
      acc = '0; f = 1'b0;
      while (!ov[d] && t < 200) begin step(); lat++; t++; end
      if (!ov[d]) begin
         chk("out_valid timeout", 64'(ov[d]), 64'd1);
         return;
      end
      a0 = oacc[d]; f0 = oovf[d];
      for (int i = 0; i < stall; i++) begin
         step();
         if (oacc[d] !== a0 || oovf[d] !== f0 || ov[d] !== 1'b1) stable = 1'b0;
      end
      if (stall > 0) chk("hold stable", 64'(stable), 64'd1);
      ordy[d] = 1'b1;
      step();
      ordy[d] = 1'b0;
      acc = a0; f = f0;
   endtask

   task automatic rand_frame(input int d);
      int n = $urandom_range(1, 64);
      longint unsigned tot = 0;
      logic [63:0] mask = (d == 0) ? 64'hFF_FFFF_FFFF : 64'hFFFF_FFFF;
      logic [31:0] s, c;
      logic [39:0] acc;
      logic f;
      int lat;
      for (int i = 0; i < n; i++) begin
         s = $urandom; c = $urandom;
         if ($urandom_range(0, 3) == 0) s = 32'hFFFF_FFFF;
         if ($urandom_range(0, 3) == 0) c = 32'h0;
         tot += 64'(s) + 64'(c);
         repeat ($urandom_range(0, 1)) step();
         send_beat(d, s, c, i == n - 1);
      end
      get_result(d, $urandom_range(0, 3), acc, f, lat);
      chk("rand acc", 64'(acc), tot & mask);
      chk("rand ovf", 64'(f), 64'(tot > mask));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, required finish within time limit");
      $fatal(1);
   end

   initial begin
      logic [39:0] acc;
      logic f;
      int lat;
      int rises;
      for (int d = 0; d < 2; d++) begin
         clr[d] = 0; iv[d] = 0; il[d] = 0; ordy[d] = 0; isum[d] = 0; icar[d] = 0;
      end
      rst = 1'b1;
      step(); step();
      chk("rst in_ready", 64'(ir[0]), 64'd0);
      chk("rst out_valid", 64'(ov[0]), 64'd0);
      chk("rst out_acc", 64'(oacc[0]), 64'd0);
      chk("rst out_ovf", 64'(oovf[0]), 64'd0);
      // clear together with reset: reset still wins, outputs stay at zero
      clr[0] = 1'b1;
      step();
      chk("rst over clear", 64'(oacc[0]), 64'd0);
      clr[0] = 1'b0;
      rst = 1'b0;
      #1;
      chk("in_ready after rst", 64'(ir[0]), 64'd1);
      step();

      // single beat 0xFF + 1
      send_beat(0, 32'h0000_00FF, 32'h0000_0001, 1'b1);
      get_result(0, 0, acc, f, lat);
      chk("single acc", 64'(acc), 64'h100);
      chk("single ovf", 64'(f), 64'd0);
      chk("single latency", 64'(lat), 64'd6);

      // three beats with a 4-cycle consumer stall
      send_beat(0, 32'd5, 32'd3, 1'b0);
      send_beat(0, 32'h10, 32'h10, 1'b0);
      send_beat(0, 32'd1, 32'd0, 1'b1);
      get_result(0, 4, acc, f, lat);
      chk("three acc", 64'(acc), 64'h29);
      chk("three ovf", 64'(f), 64'd0);
      chk("ready after take", 64'(ir[0]), 64'd1);
      chk("valid after take", 64'(ov[0]), 64'd0);

      // overflow at ACC_W=32
      send_beat(1, 32'h8000_0000, 32'h8000_0000, 1'b0);
      send_beat(1, 32'h8000_0000, 32'h8000_0000, 1'b1);
      get_result(1, 1, acc, f, lat);
      chk("ovf32 acc", 64'(acc), 64'd0);
      chk("ovf32 ovf", 64'(f), 64'd1);
      chk("ovf32 latency", 64'(lat), 64'd5);

      // exact 2^32 via the final resolve carry only
      send_beat(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
      get_result(1, 0, acc, f, lat);
      chk("cpa carry acc", 64'(acc), 64'd0);
      chk("cpa carry ovf", 64'(f), 64'd1);

      // clear in the middle of RESOLVE with a beat waiting
      send_beat(0, 32'd3, 32'd4, 1'b1);
      step();
      iv[0] = 1'b1; isum[0] = 32'd9; icar[0] = 32'd9; il[0] = 1'b1;
      chk("busy in_ready", 64'(ir[0]), 64'd0);
      clr[0] = 1'b1;
      #1;
      chk("clear in_ready", 64'(ir[0]), 64'd0);
      step();
      clr[0] = 1'b0; iv[0] = 1'b0; il[0] = 1'b0;
      rises = 0;
      for (int i = 0; i < 10; i++) begin
         if (ov[0]) rises++;
         step();
      end
      chk("clear no valid", 64'(rises), 64'd0);
      send_beat(0, 32'd7, 32'd0, 1'b1);
      get_result(0, 0, acc, f, lat);
      chk("after clear acc", 64'(acc), 64'd7);
      chk("after clear ovf", 64'(f), 64'd0);

      // randomized frames on both widths
      for (int k = 0; k < 15; k++) begin
         rand_frame(0);
         rand_frame(1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
